// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one 8-bit SDRAM port between the download writer and
// the renderer's image-fetch reader. Download bytes are buffered in a small
// write FIFO. Exactly one SDRAM command is outstanding at a time.
//
// Handshakes: a download byte is accepted on any clk_sys edge where
// dl_wr=1 and dl_wait=0 (dl_wr is ignored while dl_wait=1); rd_req is a
// level the renderer holds until the one-cycle rd_valid pulse; the SDRAM
// controller takes a command on a one-cycle sd_we/sd_rd pulse and signals
// completion by raising sd_ready again.
module sdram_arbiter #(
    parameter int AW          = 25,
    parameter int WFIFO_DEPTH = 4,
    parameter int STARVE_MAX  = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_wait,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] sd_addr,
    output logic [7:0]    sd_din,
    output logic          sd_rd,
    output logic          sd_we,
    input  logic [7:0]    sd_dout,
    input  logic          sd_ready,
    output logic          timeout_err,
    output logic [2:0]    dbg_state
);

    localparam int PW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(WFIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ISSUE = 3'd1,
        S_WR_WAIT  = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4
    } state_t;

    state_t        state;
    logic [AW-1:0] fifo_addr [WFIFO_DEPTH];
    logic [7:0]    fifo_data [WFIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [SW-1:0] starve;
    logic [TW-1:0] wait_cnt;
    logic          dl_active_q;
    logic          flush_pend;

    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          dl_rise;
    logic          flush_now;
    logic          starved;
    logic          grant_wr;
    logic          grant_rd;
    logic [AW-1:0] rd_sum;

    assign push       = dl_wr && !dl_wait;
    assign fifo_empty = (count == '0);
    assign dl_rise    = dl_active && !dl_active_q;
    // A new download discards stale bytes, but never under an in-flight command.
    assign flush_now  = (state == S_IDLE) && (dl_rise || flush_pend);
    assign starved    = (starve >= STARVE_LIM);
    // Writes win unless a read has waited through STARVE_MAX writes outside a download.
    assign grant_wr   = (state == S_IDLE) && sd_ready && !fifo_empty && !flush_now &&
                        (dl_active || !starved || !rd_req);
    assign grant_rd   = (state == S_IDLE) && sd_ready && !grant_wr && rd_req && !dl_active;
    assign pop        = grant_wr;
    assign rd_sum     = rd_base + rd_addr;
    assign dbg_state  = state;

    // Next FIFO occupancy; a flush keeps only a byte pushed in the same cycle.
    always_comb begin
        count_next = count;
        if (flush_now) begin
            count_next = push ? CW'(1) : '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // FIFO storage, written at the tail on every accepted download byte.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= dl_addr;
            fifo_data[wr_ptr] <= dl_data;
        end
    end

    // FIFO pointers, occupancy, registered full flag and deferred flush.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dl_wait     <= 1'b0;
            dl_active_q <= 1'b0;
            flush_pend  <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            count       <= count_next;
            dl_wait     <= (count_next == FULL_CNT);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (flush_now) begin
                rd_ptr     <= wr_ptr;
                flush_pend <= 1'b0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (dl_rise) begin
                    flush_pend <= 1'b1;
                end
            end
        end
    end

    // Starvation count: writes served while a read waits outside a download.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            starve <= '0;
        end else if (!rd_req || dl_active || grant_rd) begin
            starve <= '0;
        end else if (state == S_WR_ISSUE && !starved) begin
            starve <= starve + SW'(1);
        end
    end

    // Command sequencer: issue, wait for completion or timeout, return to IDLE.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            sd_addr     <= '0;
            sd_din      <= '0;
            sd_we       <= 1'b0;
            sd_rd       <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            sd_we    <= 1'b0;
            sd_rd    <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_wr) begin
                        sd_we   <= 1'b1;
                        sd_addr <= fifo_addr[rd_ptr];
                        sd_din  <= fifo_data[rd_ptr];
                        state   <= S_WR_ISSUE;
                    end else if (grant_rd) begin
                        sd_rd   <= 1'b1;
                        sd_addr <= rd_sum;
                        state   <= S_RD_ISSUE;
                    end
                end
                S_WR_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WR_WAIT;
                end
                S_RD_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_RD_WAIT;
                end
                S_WR_WAIT, S_RD_WAIT: begin
                    // sd_ready in the first wait cycle predates the command and is ignored.
                    if (wait_cnt != '0 && sd_ready) begin
                        state <= S_IDLE;
                        if (state == S_RD_WAIT) begin
                            rd_valid <= 1'b1;
                            rd_data  <= sd_dout;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Abandon the command; a read still completes with zero data.
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                        if (state == S_RD_WAIT) begin
                            rd_valid <= 1'b1;
                            rd_data  <= 8'h00;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter with a behavioural SDRAM controller model.
module tb_sdram_arbiter;

    localparam int AW = 25;
    localparam int W  = AW + 8;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          dl_active;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_wait;
    logic          rd_req;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic [AW-1:0] sd_addr;
    logic [7:0]    sd_din;
    logic          sd_rd;
    logic          sd_we;
    logic [7:0]    sd_dout;
    logic          sd_ready;
    logic          timeout_err;
    logic [2:0]    dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    // SDRAM model controls
    int   busy_cycles = 5;
    logic stuck       = 1'b0;
    logic hang_arm    = 1'b0;
    int   busy        = 0;
    logic hung        = 1'b0;
    logic [7:0] sdram_mem [4096];

    // Observation
    logic [W-1:0] exp_q[$];
    logic [W-1:0] wr_log[$];
    int cyc = 0, wr_cnt = 0, rd_cmd_cnt = 0, rv_cnt = 0;
    int last_rd_mark = 0, rd_cyc = 0, rv_cyc = 0;
    logic [7:0] last_rd_data = 8'h00;

    sdram_arbiter #(.AW(AW), .WFIFO_DEPTH(4), .STARVE_MAX(8), .TIMEOUT(255)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_wait    (dl_wait),
        .rd_req     (rd_req),
        .rd_base    (rd_base),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .sd_addr    (sd_addr),
        .sd_din     (sd_din),
        .sd_rd      (sd_rd),
        .sd_we      (sd_we),
        .sd_dout    (sd_dout),
        .sd_ready   (sd_ready),
        .timeout_err(timeout_err),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk_sys = ~clk_sys;

    // SDRAM controller model: busy for busy_cycles after a command; stuck holds
    // sd_ready low; hang_arm makes the next command never complete.
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sd_ready <= 1'b1;
            busy     <= 0;
            hung     <= 1'b0;
            sd_dout  <= 8'h00;
        end else begin
            if (sd_we) sdram_mem[sd_addr[11:0]] <= sd_din;
            if (sd_rd) sd_dout <= sdram_mem[sd_addr[11:0]];
            if (sd_we || sd_rd) busy <= busy_cycles;
            else if (busy > 0) busy <= busy - 1;
            if ((sd_we || sd_rd) && hang_arm) hung <= 1'b1;
            else if (!hang_arm) hung <= 1'b0;
            sd_ready <= !stuck && !hung && !(sd_we || sd_rd) && (busy <= 1);
        end
    end

    // Bus monitor
    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (sd_we) begin
            wr_log.push_back({sd_addr, sd_din});
            wr_cnt <= wr_cnt + 1;
        end
        if (sd_rd) begin
            rd_cmd_cnt   <= rd_cmd_cnt + 1;
            last_rd_mark <= wr_cnt;
            rd_cyc       <= cyc;
        end
        if (rd_valid) begin
            rv_cnt       <= rv_cnt + 1;
            last_rd_data <= rd_data;
            rv_cyc       <= cyc;
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " dl_wait"},     64'(dl_wait),     64'd0);
        chk({tag, " rd_valid"},    64'(rd_valid),    64'd0);
        chk({tag, " rd_data"},     64'(rd_data),     64'd0);
        chk({tag, " sd_rd"},       64'(sd_rd),       64'd0);
        chk({tag, " sd_we"},       64'(sd_we),       64'd0);
        chk({tag, " sd_addr"},     64'(sd_addr),     64'd0);
        chk({tag, " sd_din"},      64'(sd_din),      64'd0);
        chk({tag, " timeout_err"}, 64'(timeout_err), 64'd0);
        chk({tag, " state"},       64'(dbg_state),   64'd0);
    endtask

    // Drive one download byte; holds off (dl_wr=0) while dl_wait is high.
    task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
        int n = 0;
        while (dl_wait && n < 300) begin
            dl_wr = 1'b0;
            @(negedge clk_sys);
            n++;
        end
        if (n >= 300) chk("push dl_wait release", 64'(dl_wait), 64'd0);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        exp_q.push_back({a, d});
        @(negedge clk_sys);
    endtask

    task automatic wait_sd_rd(input string tag, input int limit);
        int n = 0;
        while (sd_rd !== 1'b1 && n < limit) begin @(negedge clk_sys); n++; end
        chk({tag, " sd_rd seen"}, 64'(n < limit), 64'd1);
    endtask

    task automatic wait_rd_valid(input string tag, input int limit);
        int n = 0;
        while (rd_valid !== 1'b1 && n < limit) begin @(negedge clk_sys); n++; end
        chk({tag, " rd_valid seen"}, 64'(n < limit), 64'd1);
    endtask

    task automatic wait_writes(input string tag, input int total);
        int n = 0;
        while (!(wr_cnt == total && dbg_state == 3'd0 && sd_ready) && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        chk({tag, " drained"}, 64'(n < 1000), 64'd1);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, " write count"}, 64'(wr_log.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && wr_log.size() > 0)
            chk({tag, " write addr/data"}, 64'(wr_log.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
        wr_log.delete();
    endtask

    initial begin
        reset_n   = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        rd_req    = 1'b0;
        rd_base   = '0;
        rd_addr   = '0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Burst of 6 writes, SDRAM held not-ready so the FIFO fills first
        stuck = 1'b1;
        repeat (2) @(negedge clk_sys);
        dl_active = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < 3; i++) push(AW'(i), 8'hA0 + 8'(i));
        chk("burst dl_wait after 3 pushes", 64'(dl_wait), 64'd0);
        push(AW'(3), 8'hA3);
        chk("burst dl_wait after 4 pushes", 64'(dl_wait), 64'd1);
        stuck = 1'b0;
        push(AW'(4), 8'hA4);
        push(AW'(5), 8'hA5);
        dl_wr = 1'b0;
        wait_writes("burst", 6);
        check_writes("burst");

        // Seed a byte for later reads
        push(AW'('h12A), 8'h5C);
        dl_wr = 1'b0;
        wait_writes("seed", 7);
        check_writes("seed");

        // Reads are held off during a download, served once the FIFO drains
        rd_base = AW'('h200);
        rd_addr = AW'(5);
        rd_req  = 1'b1;
        for (int i = 0; i < 10; i++) push(AW'('h200 + i), 8'h40 + 8'(i));
        dl_wr = 1'b0;
        @(negedge clk_sys);
        chk("dl_active no sd_rd", 64'(rd_cmd_cnt), 64'd0);
        dl_active = 1'b0;
        wait_rd_valid("post-download read", 600);
        rd_req = 1'b0;
        chk("post-download rd_data", 64'(rd_data), 64'h45);
        @(negedge clk_sys);
        chk("post-download writes before read", 64'(last_rd_mark), 64'd17);
        chk("post-download read count", 64'(rd_cmd_cnt), 64'd1);
        wait_writes("post-download", 17);
        check_writes("post-download");

        // Base + offset read
        rd_base = AW'('h100);
        rd_addr = AW'('h2A);
        rd_req  = 1'b1;
        wait_sd_rd("base+off", 50);
        chk("base+off sd_addr", 64'(sd_addr), 64'h12A);
        wait_rd_valid("base+off", 50);
        rd_req = 1'b0;
        chk("base+off rd_data", 64'(rd_data), 64'h5C);
        @(negedge clk_sys);
        chk("base+off single pulse", 64'(rd_valid), 64'd0);
        chk("base+off read count", 64'(rd_cmd_cnt), 64'd2);

        // Address add wraps modulo 2^AW
        rd_base = AW'('h1FF_FFFF);
        rd_addr = AW'(3);
        rd_req  = 1'b1;
        wait_sd_rd("wrap", 50);
        chk("wrap sd_addr", 64'(sd_addr), 64'h2);
        wait_rd_valid("wrap", 50);
        rd_req = 1'b0;
        chk("wrap rd_data", 64'(rd_data), 64'hA2);
        @(negedge clk_sys);

        // Starvation: continuous writes with a pending read, read after 8 writes
        stuck = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < 4; i++) push(AW'('h300 + i), 8'h60 + 8'(i));
        rd_base = AW'('h100);
        rd_addr = AW'('h2A);
        rd_req  = 1'b1;
        stuck   = 1'b0;
        for (int i = 4; i < 14; i++) begin
            if (rv_cnt != 3) rd_req = 1'b0;
            push(AW'('h300 + i), 8'h60 + 8'(i));
        end
        dl_wr = 1'b0;
        wait_writes("starve", 31);
        rd_req = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("starve writes before read", 64'(last_rd_mark), 64'd25);
        chk("starve read count", 64'(rd_cmd_cnt), 64'd4);
        chk("starve rd_data", 64'(last_rd_data), 64'h5C);
        check_writes("starve");

        // Reset in the middle of RD_WAIT
        busy_cycles = 20;
        rd_req = 1'b1;
        wait_sd_rd("mid-read reset", 50);
        @(negedge clk_sys);
        chk("mid-read state", 64'(dbg_state), 64'd4);
        #2;
        reset_n = 1'b0;
        rd_req  = 1'b0;
        #1;
        chk_all_zero("mid-read reset");
        repeat (2) @(negedge clk_sys);
        reset_n     = 1'b1;
        busy_cycles = 5;
        @(negedge clk_sys);
        rd_req = 1'b1;
        wait_rd_valid("after reset read", 50);
        rd_req = 1'b0;
        chk("after reset rd_data", 64'(rd_data), 64'h5C);
        @(negedge clk_sys);

        // Timeout: SDRAM never completes the read
        hang_arm = 1'b1;
        rd_req   = 1'b1;
        wait_sd_rd("timeout", 50);
        chk("timeout_err before expiry", 64'(timeout_err), 64'd0);
        wait_rd_valid("timeout", 400);
        rd_req = 1'b0;
        chk("timeout rd_data", 64'(rd_data), 64'h00);
        chk("timeout_err set", 64'(timeout_err), 64'd1);
        chk("timeout back to IDLE", 64'(dbg_state), 64'd0);
        @(negedge clk_sys);
        chk("timeout latency", 64'(rv_cyc - rd_cyc), 64'd256);
        hang_arm = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("timeout_err sticky", 64'(timeout_err), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("timeout_err cleared by reset", 64'(timeout_err), 64'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
